// File: rtl/nat_csum_fix.sv
// NAT checksum fix-up: holds the first 40 bytes of each frame, recomputes the
// IPv4 header checksum of plain 20-byte IPv4 headers, and re-emits the frame.
module nat_csum_fix #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [63:0]          s_axis_tdata,
    input  logic [7:0]           s_axis_tkeep,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [63:0]          m_axis_tdata,
    output logic [7:0]           m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [CNT_WIDTH-1:0] fixed_cnt
);
    localparam int HDR_BEATS = 5;

    typedef enum logic [1:0] {COLLECT = 2'd0, FLUSH = 2'd1, PASS = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [63:0]          hdr_data_q [HDR_BEATS];
    logic [7:0]           hdr_keep_q [HDR_BEATS];
    logic                 hdr_last_q [HDR_BEATS];
    logic [2:0]           idx_q, idx_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [2:0]           rd_q, rd_d;
    logic [63:0]          m_data_q, m_data_d;
    logic [7:0]           m_keep_q, m_keep_d;
    logic                 m_last_q, m_last_d;
    logic                 m_valid_q, m_valid_d;
    logic                 m_fix3_q, m_fix3_d;
    logic [CNT_WIDTH-1:0] fixed_cnt_q, fixed_cnt_d;
    logic                 s_rdy, s_acc, out_free, fix, cnt_inc;
    logic [15:0]          csum;

    // Big-endian 16-bit word starting at byte lane `lane` of a beat.
    function automatic logic [15:0] be_word(input logic [63:0] beat, input int lane);
        return {beat[8*lane +: 8], beat[8*lane+8 +: 8]};
    endfunction

    // Header bytes 14..33 span beats 1..4; the checksum word (bytes 24-25) counts as zero.
    function automatic logic [15:0] ip_csum(input logic [63:0] b1, input logic [63:0] b2,
                                            input logic [63:0] b3, input logic [63:0] b4);
        logic [19:0] s;
        s = 20'(be_word(b1, 6));
        for (int l = 0; l < 8; l += 2) s = s + 20'(be_word(b2, l));
        for (int l = 2; l < 8; l += 2) s = s + 20'(be_word(b3, l));
        s = s + 20'(be_word(b4, 0));
        s = 20'(s[15:0]) + 20'(s[19:16]);
        s = 20'(s[15:0]) + 20'(s[19:16]);
        return ~s[15:0];
    endfunction

    function automatic logic [63:0] patch_csum(input logic [63:0] beat, input logic [15:0] c);
        return {beat[63:16], c[7:0], c[15:8]};
    endfunction

    assign out_free = !m_valid_q || m_axis_tready;
    assign s_axis_tready = s_rdy && !reset;
    assign s_acc    = s_axis_tvalid && s_axis_tready;
    assign cnt_inc  = m_valid_q && m_axis_tready && m_fix3_q;

    // The buffer is stable throughout FLUSH, so the checksum settles before the first beat is loaded.
    assign csum = ip_csum(hdr_data_q[1], hdr_data_q[2], hdr_data_q[3], hdr_data_q[4]);
    assign fix  = (cnt_q == 3'd5) && (hdr_data_q[1][39:32] == 8'h08) &&
                  (hdr_data_q[1][47:40] == 8'h00) && (hdr_data_q[1][55:48] == 8'h45);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q;
        m_fix3_d    = m_fix3_q;
        s_rdy       = 1'b0;
        fixed_cnt_d = fixed_cnt_q + {{(CNT_WIDTH-1){1'b0}}, cnt_inc};
        if (out_free) begin
            m_valid_d = 1'b0;
            m_fix3_d  = 1'b0;
        end
        case (state_q)
            COLLECT: begin
                s_rdy = 1'b1;
                if (s_acc) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd4 || s_axis_tlast) begin
                        state_d = FLUSH;
                        cnt_d   = idx_q + 3'd1;
                        rd_d    = 3'd0;
                        idx_d   = 3'd0;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    m_data_d  = (rd_q == 3'd3 && fix) ? patch_csum(hdr_data_q[rd_q], csum)
                                                      : hdr_data_q[rd_q];
                    m_keep_d  = hdr_keep_q[rd_q];
                    m_last_d  = hdr_last_q[rd_q];
                    m_valid_d = 1'b1;
                    m_fix3_d  = (rd_q == 3'd3) && fix;
                    rd_d      = rd_q + 3'd1;
                    if (rd_q + 3'd1 == cnt_q)
                        state_d = hdr_last_q[rd_q] ? COLLECT : PASS;
                end
            end
            PASS: begin
                s_rdy = out_free;
                if (s_acc) begin
                    m_data_d  = s_axis_tdata;
                    m_keep_d  = s_axis_tkeep;
                    m_last_d  = s_axis_tlast;
                    m_valid_d = 1'b1;
                    if (s_axis_tlast)
                        state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= COLLECT;
            idx_q       <= 3'd0;
            cnt_q       <= 3'd0;
            rd_q        <= 3'd0;
            m_data_q    <= 64'd0;
            m_keep_q    <= 8'd0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            m_fix3_q    <= 1'b0;
            fixed_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_last_q    <= m_last_d;
            m_valid_q   <= m_valid_d;
            m_fix3_q    <= m_fix3_d;
            fixed_cnt_q <= fixed_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s_acc && state_q == COLLECT) begin
            hdr_data_q[idx_q] <= s_axis_tdata;
            hdr_keep_q[idx_q] <= s_axis_tkeep;
            hdr_last_q[idx_q] <= s_axis_tlast;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tvalid = m_valid_q;
    assign fixed_cnt     = fixed_cnt_q;
endmodule

// File: doc/nat_csum_fix.md
Name: nat_csum_fix

Overview:
Downstream stage of the NAT rewrite engine on each of the tx and rx paths. It consumes the 64-bit AXI-Stream frame output by the rewrite engine. After the source/destination address rewrite, it recomputes the IPv4 header checksum and re-emits the frame unchanged except for checksum bytes 24-25. Non-IPv4 frames, IPv4 with options, and runt frames pass through bit-exact.

Parameters:
CNT_WIDTH, 32, width of the fixed-frame counter
HDR_BEATS, 5, beats buffered before release (bytes 0..39; the IPv4 header ends at byte 33); fixed, not tunable

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
s_axis_tdata  input  64  input data; byte k of the beat at bits [8k+7:8k], lane 0 first on wire
s_axis_tkeep  input  8  input byte enables
s_axis_tlast  input  1  last beat of frame
s_axis_tvalid  input  1  input beat valid
s_axis_tready  output  1  stage accepts beat
m_axis_tdata  output  64  output data
m_axis_tkeep  output  8  output byte enables
m_axis_tlast  output  1  output last beat
m_axis_tvalid  output  1  output beat valid
m_axis_tready  input  1  downstream accepts beat
fixed_cnt  output  CNT_WIDTH  count of frames whose checksum was rewritten; wraps

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- Reset values: all m_axis_* outputs = 0, s_axis_tready = 0, fixed_cnt = 0, FSM in COLLECT, buffer empty. Reset mid-frame discards all buffered beats. The rest of that frame is treated as a new frame.
- Beat transfers on valid&&ready. Output data must hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- FSM states:
  - COLLECT: s_axis_tready=1. Accepted beats are written to buf[0..4] at index idx, and idx increments.
    - Goes to FLUSH when beat idx=4 is accepted, or when a beat with tlast=1 is accepted at any idx (short frame).
  - FLUSH: s_axis_tready=0. Emits buf[0..n-1] in order, one per m-handshake. Beat 3 is patched if fix=1.
    - After the last buffered beat transfers: goes to COLLECT if that beat had tlast=1, else to PASS.
  - PASS: one-entry output register. s_axis_tready = !m_axis_tvalid || m_axis_tready. Each beat is forwarded unmodified.
    - Goes to COLLECT after a beat with tlast=1 is accepted. The first beat of the next frame is accepted only after the FSM is back in COLLECT.
- Fix decision (fix=1): all five beats were collected, buf[1] bytes 4,5 = 0x08,0x00 (ethertype IPv4), and buf[1] byte 6 = 0x45. Otherwise fix=0 and the frame is emitted bit-exact.
- Checksum computation:
  - Words are taken from bytes 14..33, 10 big-endian 16-bit words (lower address = MSB). The word at bytes 24-25 is forced to 0.
  - Sum is 20 bits wide. Fold carry twice: s = s[15:0] + s[19:16].
  - csum = ~s[15:0].
  - Write csum[15:8] to buf[3] byte 0 and csum[7:0] to buf[3] byte 1.
  - Computation completes in the cycle beat 4 is accepted, or one registered cycle later. The first FLUSH beat must not appear before the checksum is final.
- Latency: the first output beat is valid no earlier than 1 cycle after beat 4 (or an earlier tlast) is accepted, and within 2 cycles when m_axis_tready=1.
- tkeep and tlast pass through unmodified. tkeep is not used to qualify header bytes.
- fixed_cnt increments by 1 when beat 3 of a fix=1 frame transfers on the output. It wraps 2^CNT_WIDTH-1 -> 0.
- Back-to-back frames: with m_axis_tready held at 1, there are no idle input cycles except the FLUSH stall (at most 5 cycles per frame).
- Backpressure in FLUSH or PASS never loses or duplicates beats.

Test Plan:
- Reference header: IPv4/UDP frame, 8 beats, header 45 00 00 73 00 00 40 00 40 11 00 00 c0 a8 00 01 c0 a8 00 c7 (checksum zeroed), m_axis_tready=1 -> output beat 3 tdata[15:0] = 0x61b8 (wire bytes b8 61); every other byte identical to the input; fixed_cnt = 1.
- Stale checksum: same frame with input checksum field 0xffff -> output still b8 61. Same frame with ethertype 0x86dd -> output bit-exact, fixed_cnt unchanged.
- Options and runt: IHL byte 0x46 -> unmodified. 3-beat frame with tlast on beat 2 -> 3 beats out unmodified, tlast on beat 2, FSM back in COLLECT.
- Backpressure: m_axis_tready toggled 1,0,0,1 repeating across two back-to-back 10-beat frames -> 20 beats out in order, data stable during stalls, both checksums correct, fixed_cnt = 2.
- Reset mid-frame: assert reset for 1 cycle after beat 2 is accepted -> m_axis_tvalid=0 the next cycle, fixed_cnt=0. The next full frame is fixed correctly.
- Counter wrap: with fixed_cnt preloaded to 0xffffffff (force), one fixed frame -> fixed_cnt = 0.
